// File: rtl/multi_channel_accumulator_if.sv
// Sample-in / result-out bundle for multi_channel_accumulator.
// The master drives the beats and the read select; the slave returns results and flags.
interface multi_channel_accumulator_if #(
    parameter int CHANNELS   = 4,
    parameter int DATA_WIDTH = 16,
    parameter int ACC_WIDTH  = 32
);
    localparam int CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    logic                  enable;
    logic                  valid;
    logic                  clear;
    logic [CH_W-1:0]       channel;
    logic [DATA_WIDTH-1:0] data;
    logic [CH_W-1:0]       rd_channel;

    logic                  res_valid;
    logic [CH_W-1:0]       res_channel;
    logic [ACC_WIDTH-1:0]  res_sum;
    logic [ACC_WIDTH-1:0]  rd_sum;
    logic [CHANNELS-1:0]   overflow;

    modport master (
        output enable, valid, clear, channel, data, rd_channel,
        input  res_valid, res_channel, res_sum, rd_sum, overflow
    );

    modport slave (
        input  enable, valid, clear, channel, data, rd_channel,
        output res_valid, res_channel, res_sum, rd_sum, overflow
    );
endinterface

// File: rtl/multi_channel_accumulator.sv
// N-channel accumulator with wrap/saturate overflow handling, sticky per-channel
// overflow flags, a 1-cycle result port and an independent registered read port.
module multi_channel_accumulator #(
    parameter int CHANNELS   = 4,
    parameter int DATA_WIDTH = 16,
    parameter int ACC_WIDTH  = 32,
    parameter int SIGNED     = 0,
    parameter int SATURATE   = 0
) (
    input logic                       clk,
    input logic                       rst_n,
    multi_channel_accumulator_if.slave bus
);
    localparam int CH_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int EXT_W = ACC_WIDTH + 1;

    logic [ACC_WIDTH-1:0] acc_reg [CHANNELS];
    logic [CHANNELS-1:0]  ovf_reg;
    logic                 res_valid_reg;
    logic [CH_W-1:0]      res_channel_reg;
    logic [ACC_WIDTH-1:0] res_sum_reg;
    logic [ACC_WIDTH-1:0] rd_sum_reg;

    logic                 ch_in_range;
    logic                 rd_in_range;
    logic                 accept;
    logic                 clear_only;
    logic [CH_W-1:0]      ch_idx;
    logic [CH_W-1:0]      rd_idx;
    logic [ACC_WIDTH-1:0] acc_cur;
    logic [EXT_W-1:0]     data_ext;
    logic [EXT_W-1:0]     acc_ext;
    logic [EXT_W-1:0]     sum_ext;
    logic                 ovf;
    logic [ACC_WIDTH-1:0] sat_val;
    logic [ACC_WIDTH-1:0] acc_next;
    logic [CHANNELS-1:0]  ch_hit;

    always_comb begin
        ch_in_range = (int'(bus.channel) < CHANNELS);
        rd_in_range = (int'(bus.rd_channel) < CHANNELS);
        ch_idx      = ch_in_range ? bus.channel : '0;
        rd_idx      = rd_in_range ? bus.rd_channel : '0;
        accept      = bus.enable & bus.valid & ch_in_range;
        clear_only  = bus.enable & bus.clear & ~bus.valid & ch_in_range;

        acc_cur  = acc_reg[ch_idx];
        data_ext = {{(EXT_W-DATA_WIDTH){(SIGNED != 0) && bus.data[DATA_WIDTH-1]}}, bus.data};
        acc_ext  = {(SIGNED != 0) && acc_cur[ACC_WIDTH-1], acc_cur};
        sum_ext  = acc_ext + data_ext;

        // With both operands extended one bit, signed overflow shows up as the two
        // top sum bits disagreeing; the top bit is then the true sign of the result.
        ovf = (SIGNED != 0) ? (sum_ext[ACC_WIDTH] != sum_ext[ACC_WIDTH-1]) : sum_ext[ACC_WIDTH];

        if (SIGNED != 0)
            sat_val = sum_ext[ACC_WIDTH] ? {1'b1, {(ACC_WIDTH-1){1'b0}}}
                                         : {1'b0, {(ACC_WIDTH-1){1'b1}}};
        else
            sat_val = '1;

        if (bus.clear)
            acc_next = data_ext[ACC_WIDTH-1:0];
        else if (ovf && (SATURATE != 0))
            acc_next = sat_val;
        else
            acc_next = sum_ext[ACC_WIDTH-1:0];
    end

    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_hit
        assign ch_hit[gi] = (accept | clear_only) && (ch_idx == CH_W'(gi));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < CHANNELS; c++) acc_reg[c] <= '0;
            ovf_reg         <= '0;
            res_valid_reg   <= 1'b0;
            res_channel_reg <= '0;
            res_sum_reg     <= '0;
            rd_sum_reg      <= '0;
        end else begin
            for (int c = 0; c < CHANNELS; c++) begin
                if (ch_hit[c]) begin
                    if (clear_only) begin
                        acc_reg[c] <= '0;
                        ovf_reg[c] <= 1'b0;
                    end else begin
                        acc_reg[c] <= acc_next;
                        ovf_reg[c] <= bus.clear ? 1'b0 : (ovf_reg[c] | ovf);
                    end
                end
            end
            res_valid_reg <= accept;
            if (accept) begin
                res_channel_reg <= bus.channel;
                res_sum_reg     <= acc_next;
            end
            // Read-before-write: samples the array before this edge's update lands.
            rd_sum_reg <= rd_in_range ? acc_reg[rd_idx] : '0;
        end
    end

    assign bus.res_valid   = res_valid_reg;
    assign bus.res_channel = res_channel_reg;
    assign bus.res_sum     = res_sum_reg;
    assign bus.rd_sum      = rd_sum_reg;
    assign bus.overflow    = ovf_reg;
endmodule

// File: tb/tb_multi_channel_accumulator.sv
// Scoreboard bench: two accumulator configurations (unsigned wrap, 5 channels;
// signed saturate, 4 channels) driven with directed beats and checked by monitors.
module tb_multi_channel_accumulator;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0]  ch;
        logic [31:0] sum;
        logic [31:0] cyc;
    } exp_t;

    exp_t q_u[$];
    exp_t q_s[$];
    exp_t e_u;
    exp_t e_s;
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    bit   verbose  = 1'b1;

    always @(posedge clk) cyc <= cyc + 1;

    multi_channel_accumulator_if #(.CHANNELS(5), .DATA_WIDTH(16), .ACC_WIDTH(32)) bus_u ();
    multi_channel_accumulator_if #(.CHANNELS(4), .DATA_WIDTH(16), .ACC_WIDTH(32)) bus_s ();

    multi_channel_accumulator #(
        .CHANNELS(5), .DATA_WIDTH(16), .ACC_WIDTH(32), .SIGNED(0), .SATURATE(0)
    ) dut_u (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_u)
    );

    multi_channel_accumulator #(
        .CHANNELS(4), .DATA_WIDTH(16), .ACC_WIDTH(32), .SIGNED(1), .SATURATE(1)
    ) dut_s (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_s)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    task automatic u_drive(input bit en, input bit v, input bit clr, input int ch, input logic [15:0] d);
        bus_u.enable  = en;
        bus_u.valid   = v;
        bus_u.clear   = clr;
        bus_u.channel = 3'(ch);
        bus_u.data    = d;
    endtask

    task automatic s_drive(input bit en, input bit v, input bit clr, input int ch, input logic [15:0] d);
        bus_s.enable  = en;
        bus_s.valid   = v;
        bus_s.clear   = clr;
        bus_s.channel = 2'(ch);
        bus_s.data    = d;
    endtask

    task automatic u_beat(input int ch, input logic [15:0] d, input bit clr, input logic [31:0] req);
        @(negedge clk);
        u_drive(1'b1, 1'b1, clr, ch, d);
        q_u.push_back('{ch: 8'(ch), sum: req, cyc: 32'(cyc + 1)});
    endtask

    task automatic s_beat(input int ch, input logic [15:0] d, input bit clr, input logic [31:0] req);
        @(negedge clk);
        s_drive(1'b1, 1'b1, clr, ch, d);
        q_s.push_back('{ch: 8'(ch), sum: req, cyc: 32'(cyc + 1)});
    endtask

    task automatic u_idle();
        @(negedge clk);
        u_drive(1'b1, 1'b0, 1'b0, 0, 16'h0);
    endtask

    task automatic s_idle();
        @(negedge clk);
        s_drive(1'b1, 1'b0, 1'b0, 0, 16'h0);
    endtask

    // Result monitors: every o_VALID beat must match the oldest expected entry,
    // including the cycle in which it was due.
    initial forever begin
        @(posedge clk);
        #1;
        if (bus_u.res_valid === 1'b1) begin
            checks++;
            if (q_u.size() == 0) begin
                failures++;
                $display("FAIL u_unexpected_beat ch=%0d sum=0x%0h required=no beat",
                         bus_u.res_channel, bus_u.res_sum);
            end else begin
                e_u = q_u.pop_front();
                if (int'(bus_u.res_channel) != int'(e_u.ch) || bus_u.res_sum !== e_u.sum
                    || cyc != int'(e_u.cyc)) begin
                    failures++;
                    $display("FAIL u_beat actual ch=%0d sum=0x%0h cyc=%0d required ch=%0d sum=0x%0h cyc=%0d",
                             bus_u.res_channel, bus_u.res_sum, cyc, e_u.ch, e_u.sum, e_u.cyc);
                end else if (verbose) begin
                    $display("u beat ch=%0d sum=0x%08h cyc=%0d ok", e_u.ch, e_u.sum, cyc);
                end
            end
        end
    end

    initial forever begin
        @(posedge clk);
        #1;
        if (bus_s.res_valid === 1'b1) begin
            checks++;
            if (q_s.size() == 0) begin
                failures++;
                $display("FAIL s_unexpected_beat ch=%0d sum=0x%0h required=no beat",
                         bus_s.res_channel, bus_s.res_sum);
            end else begin
                e_s = q_s.pop_front();
                if (int'(bus_s.res_channel) != int'(e_s.ch) || bus_s.res_sum !== e_s.sum
                    || cyc != int'(e_s.cyc)) begin
                    failures++;
                    $display("FAIL s_beat actual ch=%0d sum=0x%0h cyc=%0d required ch=%0d sum=0x%0h cyc=%0d",
                             bus_s.res_channel, bus_s.res_sum, cyc, e_s.ch, e_s.sum, e_s.cyc);
                end else if (verbose) begin
                    $display("s beat ch=%0d sum=0x%08h cyc=%0d ok", e_s.ch, e_s.sum, cyc);
                end
            end
        end
    end

    initial begin
        longint m_u;
        longint m_s;
        longint n_s;

        rst_n = 1'b1;
        u_drive(1'b0, 1'b0, 1'b0, 0, 16'h0);
        s_drive(1'b0, 1'b0, 1'b0, 0, 16'h0);
        bus_u.rd_channel = '0;
        bus_s.rd_channel = '0;
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);

        // Reset state
        chk("rst_u_valid", 64'(bus_u.res_valid), 64'h0);
        chk("rst_u_sum", 64'(bus_u.res_sum), 64'h0);
        chk("rst_u_rd", 64'(bus_u.rd_sum), 64'h0);
        chk("rst_u_ovf", 64'(bus_u.overflow), 64'h0);
        chk("rst_s_valid", 64'(bus_s.res_valid), 64'h0);
        chk("rst_s_ovf", 64'(bus_s.overflow), 64'h0);
        rst_n = 1'b1;

        // Consecutive beats, latency 1
        u_beat(0, 16'd5, 1'b0, 32'd5);
        u_beat(0, 16'd7, 1'b0, 32'd12);
        u_beat(2, 16'd3, 1'b0, 32'd3);
        u_idle();
        bus_u.rd_channel = 3'd0;
        @(negedge clk);
        chk("t1_rd_ch0", 64'(bus_u.rd_sum), 64'd12);
        bus_u.rd_channel = 3'd2;
        @(negedge clk);
        chk("t1_rd_ch2", 64'(bus_u.rd_sum), 64'd3);

        // Disabled beat and out-of-range channel are dropped
        @(negedge clk);
        u_drive(1'b0, 1'b1, 1'b1, 4, 16'd50);
        @(negedge clk);
        u_drive(1'b1, 1'b1, 1'b0, 6, 16'd77);
        u_idle();
        bus_u.rd_channel = 3'd4;
        @(negedge clk);
        chk("t5_ch4_unchanged", 64'(bus_u.rd_sum), 64'h0);
        chk("t5_flags_unchanged", 64'(bus_u.overflow), 64'h0);
        bus_u.rd_channel = 3'd0;
        @(negedge clk);
        chk("t5_ch0_unchanged", 64'(bus_u.rd_sum), 64'd12);
        bus_u.rd_channel = 3'd6;
        @(negedge clk);
        chk("t5_rd_out_of_range", 64'(bus_u.rd_sum), 64'h0);
        u_beat(4, 16'd9, 1'b0, 32'd9);
        u_idle();
        bus_u.rd_channel = 3'd4;
        @(negedge clk);
        chk("t5_ch4_beat", 64'(bus_u.rd_sum), 64'd9);

        // Long runs: unsigned wrap on dut_u alongside signed saturation on dut_s
        verbose = 1'b0;
        fork
            begin
                u_beat(1, 16'hFFFF, 1'b1, 32'h0000FFFF);
                m_u = 64'h0000FFFF;
                while (m_u + 64'h0000FFFF < 64'h1_0000_0000) begin
                    m_u = m_u + 64'h0000FFFF;
                    u_beat(1, 16'hFFFF, 1'b0, 32'(m_u));
                end
                u_idle();
                bus_u.rd_channel = 3'd1;
                @(negedge clk);
                chk("t2_prewrap_value", 64'(bus_u.rd_sum), 64'hFFFFFFFF);
                chk("t2_prewrap_flags", 64'(bus_u.overflow), 64'h0);
                u_beat(1, 16'hFFFF, 1'b0, 32'h0000FFFE);
                u_idle();
                @(negedge clk);
                chk("t2_wrap_flags", 64'(bus_u.overflow), 64'b00010);
                chk("t2_wrap_value", 64'(bus_u.rd_sum), 64'h0000FFFE);
            end
            begin
                m_s = 0;
                for (int i = 0; i < 65542; i++) begin
                    n_s = m_s + 32767;
                    if (n_s > 64'sd2147483647) n_s = 64'sd2147483647;
                    s_beat(3, 16'h7FFF, 1'b0, 32'(n_s));
                    m_s = n_s;
                end
                s_idle();
                bus_s.rd_channel = 2'd3;
                @(negedge clk);
                chk("t3_sat_flags", 64'(bus_s.overflow), 64'b1000);
                chk("t3_sat_value", 64'(bus_s.rd_sum), 64'h7FFFFFFF);
                s_beat(3, 16'h8000, 1'b0, 32'h7FFF7FFF);
                s_idle();
                @(negedge clk);
                chk("t3_flag_sticky", 64'(bus_s.overflow), 64'b1000);
            end
        join
        verbose = 1'b1;

        // Clear-load drops the sticky flag
        u_beat(1, 16'h0010, 1'b1, 32'h00000010);
        u_idle();
        @(negedge clk);
        chk("clrload_u_flags", 64'(bus_u.overflow), 64'h0);

        // Clear without valid; read port shows pre-clear value that cycle
        @(negedge clk);
        s_drive(1'b1, 1'b0, 1'b1, 3, 16'h0);
        bus_s.rd_channel = 2'd3;
        @(negedge clk);
        s_drive(1'b1, 1'b0, 1'b0, 0, 16'h0);
        chk("t4_rd_old", 64'(bus_s.rd_sum), 64'h7FFF7FFF);
        chk("t4_flag_cleared", 64'(bus_s.overflow), 64'h0);
        @(negedge clk);
        chk("t4_rd_cleared", 64'(bus_s.rd_sum), 64'h0);

        // Negative sample is sign-extended on clear-load
        s_beat(2, 16'h8000, 1'b1, 32'hFFFF8000);
        s_idle();
        bus_s.rd_channel = 2'd2;

        // Asynchronous reset while a result is being presented
        s_beat(0, 16'd100, 1'b0, 32'd100);
        @(posedge clk);
        #3;
        s_drive(1'b1, 1'b0, 1'b0, 0, 16'h0);
        chk("t6_valid_before", 64'(bus_s.res_valid), 64'h1);
        chk("t6_rd_before", 64'(bus_s.rd_sum), 64'hFFFF8000);
        rst_n = 1'b0;
        #1;
        chk("t6_s_valid", 64'(bus_s.res_valid), 64'h0);
        chk("t6_s_sum", 64'(bus_s.res_sum), 64'h0);
        chk("t6_s_rd", 64'(bus_s.rd_sum), 64'h0);
        chk("t6_s_ch", 64'(bus_s.res_channel), 64'h0);
        chk("t6_u_sum", 64'(bus_u.res_sum), 64'h0);
        chk("t6_u_rd", 64'(bus_u.rd_sum), 64'h0);
        chk("t6_u_ovf", 64'(bus_u.overflow), 64'h0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        s_beat(0, 16'hFFFF, 1'b0, 32'hFFFFFFFF);
        s_idle();
        bus_s.rd_channel = 2'd2;
        @(negedge clk);
        chk("t6_ch2_cleared", 64'(bus_s.rd_sum), 64'h0);
        chk("t6_s_flags", 64'(bus_s.overflow), 64'h0);

        repeat (3) @(negedge clk);
        chk("u_queue_drained", 64'(q_u.size()), 64'h0);
        chk("s_queue_drained", 64'(q_s.size()), 64'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
